mor1kx_spr_master: RTL and testbench



---
 rtl/mor1kx_spr_pkg.sv | 37 +++
 rtl/mor1kx_spr_timeout_ctr.sv | 31 +++
 rtl/mor1kx_spr_master.sv | 159 +++++++++++++++
 tb/tb_mor1kx_spr_master.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_spr_pkg.sv
// Shared definitions for the SPR bus initiator: state encoding, the group
// field of an SPR address, group numbers and the default timeout.
package mor1kx_spr_pkg;

    // Initiator FSM states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } spr_state_e;

    // Group number lives in address bits [15:11]
    localparam int unsigned SprGroupLsb   = 11;
    localparam int unsigned SprGroupWidth = 5;

    // Group numbers
    localparam logic [SprGroupWidth-1:0] SprGroupSys  = 5'd0;
    localparam logic [SprGroupWidth-1:0] SprGroupDmmu = 5'd1;
    localparam logic [SprGroupWidth-1:0] SprGroupImmu = 5'd2;
    localparam logic [SprGroupWidth-1:0] SprGroupDc   = 5'd3;
    localparam logic [SprGroupWidth-1:0] SprGroupIc   = 5'd4;
    localparam logic [SprGroupWidth-1:0] SprGroupMac  = 5'd5;
    localparam logic [SprGroupWidth-1:0] SprGroupDu   = 5'd6;
    localparam logic [SprGroupWidth-1:0] SprGroupPc   = 5'd7;
    localparam logic [SprGroupWidth-1:0] SprGroupPm   = 5'd8;
    localparam logic [SprGroupWidth-1:0] SprGroupPic  = 5'd9;
    localparam logic [SprGroupWidth-1:0] SprGroupTt   = 5'd10;
    localparam logic [SprGroupWidth-1:0] SprGroupFpu  = 5'd11;

    localparam int unsigned SprTimeoutDefault = 16;

    // Extract the group field of an SPR address
    function automatic logic [SprGroupWidth-1:0] spr_group(input logic [15:0] addr);
        return addr[SprGroupLsb +: SprGroupWidth];
    endfunction

endpackage

// File: rtl/mor1kx_spr_timeout_ctr.sv
// 8-bit access timeout counter: synchronous clear, count enable, and an
// expire flag asserted while the count equals Limit.
module mor1kx_spr_timeout_ctr #(
    parameter int unsigned Limit = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [7:0] r_cnt;

    // Count register; clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Expire flag at the limit
    always_comb begin
        o_expire = (r_cnt == 8'(Limit));
    end

endmodule

// File: rtl/mor1kx_spr_master.sv
// SPR bus initiator: takes one mtspr/mfspr request at a time, strobes the
// one-hot group access, waits for that group's ack (or a timeout) and
// returns a response.
// Optional macro MOR1KX_SPR_GROUP_MASK_EN: requests to groups whose bit in
// OPTION_SPR_GROUP_PRESENT is 0 are answered with an error, no bus cycle.
module mor1kx_spr_master
    import mor1kx_spr_pkg::*;
#(
    parameter int unsigned OPTION_SPR_TIMEOUT       = SprTimeoutDefault,
    parameter logic [31:0] OPTION_SPR_GROUP_PRESENT = 32'hffffffff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic [31:0] spr_access_o,
    output logic        spr_we_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_dat_o,
    input  logic [31:0] spr_bus_ack_i,
    input  logic [31:0] spr_bus_dat_i
);

    spr_state_e r_state, w_state_d;

    logic        r_we;
    logic [15:0] r_addr;
    logic [31:0] r_dat;
    logic [31:0] r_rsp_dat, w_rsp_dat_d;
    logic        r_rsp_err, w_rsp_err_d;

    logic        w_load;
    logic        w_ctr_clr;
    logic        w_ctr_en;
    logic        w_expire;
    logic        w_ack;
    logic        w_absent;
    logic [SprGroupWidth-1:0] w_group;

    mor1kx_spr_timeout_ctr #(
        .Limit (OPTION_SPR_TIMEOUT - 1)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_ctr_clr),
        .i_en     (w_ctr_en),
        .o_expire (w_expire)
    );

`ifdef MOR1KX_SPR_GROUP_MASK_EN
    // Absent-group check on the incoming request
    always_comb begin
        w_absent = !OPTION_SPR_GROUP_PRESENT[spr_group(req_addr_i)];
    end
`else
    logic w_unused_present;

    // Every group goes on the bus; the presence mask is not consulted
    always_comb begin
        w_absent         = 1'b0;
        w_unused_present = ^OPTION_SPR_GROUP_PRESENT;
    end
`endif

    // Only the accessed group's ack counts; other ack bits are ignored
    always_comb begin
        w_group = spr_group(r_addr);
        w_ack   = spr_bus_ack_i[w_group];
    end

    // Next-state and response capture
    always_comb begin
        w_state_d   = r_state;
        w_rsp_dat_d = r_rsp_dat;
        w_rsp_err_d = r_rsp_err;
        w_load      = 1'b0;
        w_ctr_clr   = 1'b0;
        w_ctr_en    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (req_valid_i) begin
                    w_load      = 1'b1;
                    w_ctr_clr   = 1'b1;
                    w_rsp_dat_d = 32'd0;
                    if (w_absent) begin
                        w_rsp_err_d = 1'b1;
                        w_state_d   = StResp;
                    end else begin
                        w_rsp_err_d = 1'b0;
                        w_state_d   = StAccess;
                    end
                end
            end
            StAccess: begin
                // Ack in the last timeout cycle takes priority over expiry
                if (w_ack) begin
                    w_rsp_dat_d = r_we ? 32'd0 : spr_bus_dat_i;
                    w_rsp_err_d = 1'b0;
                    w_state_d   = StResp;
                end else if (w_expire) begin
                    w_rsp_dat_d = 32'd0;
                    w_rsp_err_d = 1'b1;
                    w_state_d   = StResp;
                end else begin
                    w_ctr_en = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, captured request and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_we      <= 1'b0;
            r_addr    <= 16'd0;
            r_dat     <= 32'd0;
            r_rsp_dat <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_rsp_dat <= w_rsp_dat_d;
            r_rsp_err <= w_rsp_err_d;
            if (w_load) begin
                r_we   <= req_we_i;
                r_addr <= req_addr_i;
                r_dat  <= req_dat_i;
            end
        end
    end

    // Handshake and bus outputs decoded from state
    always_comb begin
        req_ready_o  = (r_state == StIdle);
        rsp_valid_o  = (r_state == StResp);
        rsp_dat_o    = r_rsp_dat;
        rsp_err_o    = r_rsp_err;
        spr_access_o = (r_state == StAccess) ? (32'd1 << w_group) : 32'd0;
        spr_we_o     = (r_state == StAccess) && r_we;
        spr_addr_o   = r_addr;
        spr_dat_o    = r_dat;
    end

endmodule

// File: tb/tb_mor1kx_spr_master.sv
// Directed bench for mor1kx_spr_master with TIMEOUT=16 and group 20 absent
// from the presence mask (only matters with MOR1KX_SPR_GROUP_MASK_EN).
module tb_mor1kx_spr_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [15:0] req_addr_i;
    logic [31:0] req_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic [31:0] spr_access_o;
    logic        spr_we_o;
    logic [15:0] spr_addr_o;
    logic [31:0] spr_dat_o;
    logic [31:0] spr_bus_ack_i;
    logic [31:0] spr_bus_dat_i;

    int errors = 0;
    int checks = 0;
    int n;

    mor1kx_spr_master #(
        .OPTION_SPR_TIMEOUT       (16),
        .OPTION_SPR_GROUP_PRESENT (32'hffef_ffff)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_dat_i     (req_dat_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_dat_o     (rsp_dat_o),
        .rsp_err_o     (rsp_err_o),
        .spr_access_o  (spr_access_o),
        .spr_we_o      (spr_we_o),
        .spr_addr_o    (spr_addr_o),
        .spr_dat_o     (spr_dat_o),
        .spr_bus_ack_i (spr_bus_ack_i),
        .spr_bus_dat_i (spr_bus_dat_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid_i   = 1'b0;
        req_we_i      = 1'b0;
        req_addr_i    = 16'd0;
        req_dat_i     = 32'd0;
        rsp_ready_i   = 1'b0;
        spr_bus_ack_i = 32'd0;
        spr_bus_dat_i = 32'd0;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_dat", rsp_dat_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_access", spr_access_o, 32'd0);
        chk("rst_we", 32'(spr_we_o), 32'd0);
        chk("rst_addr", 32'(spr_addr_o), 32'd0);
        chk("rst_dat", spr_dat_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // PIC read, zero-wait ack
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h4800;
        chk("pic_ready_idle", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        chk("pic_access", spr_access_o, 32'h0000_0200);
        chk("pic_ready_busy", 32'(req_ready_o), 32'd0);
        chk("pic_we", 32'(spr_we_o), 32'd0);
        chk("pic_no_rsp_yet", 32'(rsp_valid_o), 32'd0);
        spr_bus_ack_i = 32'h0000_0200; spr_bus_dat_i = 32'h0000_0005;
        tick();
        spr_bus_ack_i = 32'd0; spr_bus_dat_i = 32'd0;
        chk("pic_access_drop", spr_access_o, 32'd0);
        chk("pic_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("pic_rsp_dat", rsp_dat_o, 32'h0000_0005);
        chk("pic_rsp_err", 32'(rsp_err_o), 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("pic_back_idle", 32'(req_ready_o), 32'd1);
        chk("pic_rsp_gone", 32'(rsp_valid_o), 32'd0);

        // Write to tick timer with 3 wait states
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 16'h5000; req_dat_i = 32'hA5A5_0000;
        tick();
        req_valid_i = 1'b0; req_we_i = 1'b0; req_dat_i = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            chk("tt_access", spr_access_o, 32'h0000_0400);
            chk("tt_we", 32'(spr_we_o), 32'd1);
            chk("tt_dat_stable", spr_dat_o, 32'hA5A5_0000);
            chk("tt_addr_stable", 32'(spr_addr_o), 32'h0000_5000);
            if (i == 3) begin
                spr_bus_ack_i = 32'h0000_0400; spr_bus_dat_i = 32'hDEAD_BEEF;
            end
            tick();
        end
        spr_bus_ack_i = 32'd0; spr_bus_dat_i = 32'd0;
        chk("tt_access_drop", spr_access_o, 32'd0);
        chk("tt_we_drop", 32'(spr_we_o), 32'd0);
        chk("tt_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("tt_rsp_dat", rsp_dat_o, 32'd0);
        chk("tt_rsp_err", 32'(rsp_err_o), 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Read group 5 with no ack: 16 access cycles then error
        req_valid_i = 1'b1; req_addr_i = 16'h2800;
        tick();
        req_valid_i = 1'b0;
        n = 0;
        while (spr_access_o == 32'h0000_0020 && n < 40) begin
            n++;
            tick();
        end
        chk("to_access_cycles", 32'(n), 32'd16);
        chk("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("to_rsp_err", 32'(rsp_err_o), 32'd1);
        chk("to_rsp_dat", rsp_dat_o, 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Ack in the final timeout cycle beats the timeout
        req_valid_i = 1'b1; req_addr_i = 16'h4800;
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("last_access_held", spr_access_o, 32'h0000_0200);
        spr_bus_ack_i = 32'h0000_0200; spr_bus_dat_i = 32'h0000_0077;
        tick();
        spr_bus_ack_i = 32'd0; spr_bus_dat_i = 32'd0;
        chk("last_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("last_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("last_rsp_dat", rsp_dat_o, 32'h0000_0077);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Ack on a foreign bit is ignored
        req_valid_i = 1'b1; req_addr_i = 16'h4800;
        tick();
        req_valid_i = 1'b0;
        spr_bus_ack_i = 32'h0000_0008;
        tick();
        chk("wrong_ack_access", spr_access_o, 32'h0000_0200);
        chk("wrong_ack_no_rsp", 32'(rsp_valid_o), 32'd0);
        spr_bus_ack_i = 32'h0000_0200; spr_bus_dat_i = 32'h0000_1234;
        tick();
        spr_bus_ack_i = 32'd0; spr_bus_dat_i = 32'd0;
        chk("right_ack_rsp", 32'(rsp_valid_o), 32'd1);
        chk("right_ack_dat", rsp_dat_o, 32'h0000_1234);

        // Backpressure on the response with a new request pending
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h5000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_rsp_dat", rsp_dat_o, 32'h0000_1234);
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("bp_exit_ready", 32'(req_ready_o), 32'd1);
        chk("bp_exit_rsp", 32'(rsp_valid_o), 32'd0);
        tick();
        req_valid_i = 1'b0;
        chk("bp_new_access", spr_access_o, 32'h0000_0400);

        // Asynchronous reset in the middle of an access
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_access", spr_access_o, 32'd0);
        chk("arst_req_ready", 32'(req_ready_o), 32'd1);
        chk("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("arst_addr", 32'(spr_addr_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("arst_idle", 32'(req_ready_o), 32'd1);

`ifdef MOR1KX_SPR_GROUP_MASK_EN
        // Absent group 20: error response after one cycle, no bus access
        req_valid_i = 1'b1; req_addr_i = 16'hA000;
        tick();
        req_valid_i = 1'b0;
        chk("mask_access", spr_access_o, 32'd0);
        chk("mask_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("mask_rsp_err", 32'(rsp_err_o), 32'd1);
        chk("mask_rsp_dat", rsp_dat_o, 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
